// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_rx
// Purpose  : Host-side PS/2 keyboard receiver: conditions the pins, deframes
//            11-bit frames and decodes E0/F0 prefixes into key events.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keyboard_rx #(
    parameter int FILTER_LEN   = 8,
    parameter int TIMEOUT      = 100000,
    parameter int PARITY_CHECK = 0
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] RAW_DATA,
    output logic       RAW_VALID,
    output logic [7:0] SCANCODE,
    output logic       BREAK,
    output logic       EXTENDED,
    output logic       KEY_VALID,
    output logic       ERROR
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

    // Bit 0 carries PS2_CLK, bit 1 carries PS2_DATA.
    logic [1:0]    sync1_q, sync2_q, filt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          w_fall;
    logic          w_data;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [7:0]    raw_data_q, raw_data_d, scancode_q, scancode_d;
    logic          raw_valid_q, raw_valid_d, key_valid_q, key_valid_d;
    logic          break_q, break_d, extended_q, extended_d, error_q, error_d;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            filt_q    <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            sync1_q <= {PS2_DATA, PS2_CLK};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FW'(1);
                end
            end
        end
    end

    // The edge is flagged on the cycle the filtered clock is about to drop.
    assign w_fall = filt_q[0] && !sync2_q[0] && (fcnt_q[0] == FW'(FILTER_LEN - 1));
    assign w_data = filt_q[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = tmo_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        raw_data_d  = raw_data_q;
        scancode_d  = scancode_q;
        break_d     = break_q;
        extended_d  = extended_q;
        raw_valid_d = 1'b0;
        key_valid_d = 1'b0;
        error_d     = 1'b0;

        if (state_q != IDLE) begin
            if (w_fall)
                tmo_d = '0;
            else if (tmo_q != TW'(TIMEOUT))
                tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (w_fall && !w_data) begin
                    state_d = SHIFT;
                    cnt_d   = 3'd0;
                end
            end
            SHIFT: begin
                if (w_fall) begin
                    shift_d[cnt_q] = w_data;
                    if (cnt_q == 3'd7)
                        state_d = PARITY;
                    else
                        cnt_d = cnt_q + 3'd1;
                end
            end
            PARITY: begin
                if (w_fall) begin
                    par_d   = w_data;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (w_fall) begin
                    state_d = IDLE;
                    if (w_data && (PARITY_CHECK == 0 || (^shift_q ^ par_q))) begin
                        raw_data_d  = shift_q;
                        raw_valid_d = 1'b1;
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            scancode_d  = shift_q;
                            break_d     = brk_q;
                            extended_d  = ext_q;
                            key_valid_d = 1'b1;
                            ext_d       = 1'b0;
                            brk_d       = 1'b0;
                        end
                    end else begin
                        error_d = 1'b1;
                        ext_d   = 1'b0;
                        brk_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled frame is abandoned along with any pending prefixes.
        if (state_q != IDLE && !w_fall && tmo_q == TW'(TIMEOUT - 1)) begin
            state_d     = IDLE;
            error_d     = 1'b1;
            raw_valid_d = 1'b0;
            key_valid_d = 1'b0;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            raw_data_q  <= '0;
            scancode_q  <= '0;
            break_q     <= 1'b0;
            extended_q  <= 1'b0;
            raw_valid_q <= 1'b0;
            key_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            raw_data_q  <= raw_data_d;
            scancode_q  <= scancode_d;
            break_q     <= break_d;
            extended_q  <= extended_d;
            raw_valid_q <= raw_valid_d;
            key_valid_q <= key_valid_d;
            error_q     <= error_d;
        end
    end

    assign RAW_DATA  = raw_data_q;
    assign RAW_VALID = raw_valid_q;
    assign SCANCODE  = scancode_q;
    assign BREAK     = break_q;
    assign EXTENDED  = extended_q;
    assign KEY_VALID = key_valid_q;
    assign ERROR     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keyboard_rx
// Purpose  : Self-checking bench for ps2_keyboard_rx (table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_rx;

    localparam int FL   = 8;
    localparam int TO   = 200;
    localparam int HALF = 20;   // PS/2 half period in system clocks, shortened

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2c = 1'b1;
    logic ps2d = 1'b1;

    logic [7:0] raw_data, scancode, np_raw_data, np_scancode;
    logic raw_valid, brk, ext, key_valid, err;
    logic np_raw_valid, np_brk, np_ext, np_key_valid, np_err;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT(TO), .PARITY_CHECK(1)) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .PS2_CLK(ps2c), .PS2_DATA(ps2d),
        .RAW_DATA(raw_data), .RAW_VALID(raw_valid), .SCANCODE(scancode),
        .BREAK(brk), .EXTENDED(ext), .KEY_VALID(key_valid), .ERROR(err));

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT(TO), .PARITY_CHECK(0)) dut_np (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .PS2_CLK(ps2c), .PS2_DATA(ps2d),
        .RAW_DATA(np_raw_data), .RAW_VALID(np_raw_valid), .SCANCODE(np_scancode),
        .BREAK(np_brk), .EXTENDED(np_ext), .KEY_VALID(np_key_valid), .ERROR(np_err));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int np_raw_cnt = 0;
    int np_raw_exp = 0;
    logic raw_prev = 1'b0;
    logic key_prev = 1'b0;

    logic [7:0] raw_q [$];
    logic [9:0] key_q [$];   // {scancode, break, extended}

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         exp_key;
        logic [7:0] exp_code;
        bit         exp_brk;
        bit         exp_ext;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (raw_valid) begin
            if (raw_q.size() == 0) check("unexpected_raw", 32'(raw_data), 32'h100);
            else check("raw_data", 32'(raw_data), 32'(raw_q.pop_front()));
        end
        if (key_valid) begin
            if (key_q.size() == 0) check("unexpected_key", 32'(scancode), 32'h100);
            else check("key_event", 32'({scancode, brk, ext}), 32'(key_q.pop_front()));
        end
        if (raw_valid && err) check("raw_and_error", 32'(err), 32'(0));
        if (raw_valid && raw_prev) check("raw_strobe_len", 32'(raw_valid), 32'(0));
        if (key_valid && key_prev) check("key_strobe_len", 32'(key_valid), 32'(0));
        if (err) err_cnt++;
        if (np_raw_valid) np_raw_cnt++;
        raw_prev = raw_valid;
        key_prev = key_valid;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] d, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            wait_cyc(HALF);
            ps2c = 1'b0;
            wait_cyc(HALF);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    task automatic expect_frame(input logic [7:0] d, input bit key, input bit b, input bit e);
        raw_q.push_back(d);
        np_raw_exp++;
        if (key) key_q.push_back({d, b, e});
        send_bits(d, 1'b0, 11);
        wait_cyc(60);
        check("raw_pending", 32'(raw_q.size()), 32'(0));
        check("key_pending", 32'(key_q.size()), 32'(0));
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, np0, n;
        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b0};
        vecs[3]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0};
        vecs[4]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1};
        vecs[7]  = '{8'h75, 1'b0, 1'b1, 8'h75, 1'b0, 1'b0};
        vecs[8]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0};
        vecs[11] = '{8'hE1, 1'b0, 1'b1, 8'hE1, 1'b0, 1'b0};

        // Reset state
        wait_cyc(3);
        @(negedge clk);
        check("reset_outputs", 32'({raw_data, raw_valid, scancode, brk, ext, key_valid, err}), 32'(0));
        rst_n = 1'b1;
        wait_cyc(20);

        for (int i = 0; i < 12; i++)
            expect_frame(vecs[i].data, vecs[i].exp_key, vecs[i].exp_brk, vecs[i].exp_ext);
        check("no_error_table", 32'(err_cnt), 32'(0));

        // Bad parity: strict instance rejects, lenient instance accepts
        e0 = err_cnt; np0 = np_raw_cnt;
        send_bits(8'h1C, 1'b1, 11);
        wait_cyc(60);
        np_raw_exp++;
        check("parity_error", 32'(err_cnt - e0), 32'(1));
        check("parity_scancode_held", 32'(scancode), 32'hE1);
        check("noparity_accept", 32'(np_raw_cnt - np0), 32'(1));
        check("noparity_data", 32'(np_raw_data), 32'h1C);

        // Timeout after 4 data bits, with a pending break prefix that must clear
        expect_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        e0 = err_cnt;
        send_bits(8'h05, 1'b0, 5);
        n = HALF;
        while (err_cnt == e0 && n < TO + HALF + 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_error", 32'(err_cnt - e0), 32'(1));
        check("timeout_latency_ok", 32'(n >= TO && n <= TO + FL + 4), 32'(1));
        wait_cyc(10);
        expect_frame(8'h45, 1'b1, 1'b0, 1'b0);
        check("timeout_single_error", 32'(err_cnt - e0), 32'(1));

        // Short glitch on PS2_CLK with data low must not start a frame
        e0 = err_cnt;
        ps2d = 1'b0;
        wait_cyc(2);
        ps2c = 1'b0;
        wait_cyc(FL - 3);
        ps2c = 1'b1;
        wait_cyc(2);
        ps2d = 1'b1;
        wait_cyc(TO + 20);
        check("glitch_no_error", 32'(err_cnt - e0), 32'(0));
        expect_frame(8'h1C, 1'b1, 1'b0, 1'b0);

        // Reset mid-frame after a break prefix
        expect_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_bits(8'h0F, 1'b0, 4);
        rst_n = 1'b0;
        wait_cyc(3);
        @(negedge clk);
        check("midreset_outputs", 32'({raw_data, raw_valid, scancode, brk, ext, key_valid, err}), 32'(0));
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(30);
        expect_frame(8'h1C, 1'b1, 1'b0, 1'b0);

        check("total_errors", 32'(err_cnt), 32'(2));
        check("noparity_raw_count", 32'(np_raw_cnt), 32'(np_raw_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
Host-side PS/2 receiver: it takes the PS2_CLK/PS2_DATA pins driven by a keyboard and delivers decoded scan codes to the BBC keyboard matrix emulation logic.
- Synchronises and deglitches both lines, then deframes 11-bit PS/2 frames.
- Tracks the E0 (extended) and F0 (break) prefixes.
- Emits one-cycle strobes: one per raw byte and one per complete key event.
- Sits directly behind the top-level PS2 pins in TOP. Receive only; it never drives the lines.

Parameters:
FILTER_LEN, 8, consecutive system-clock cycles a synchronised line must hold a new level before the filtered level changes.
TIMEOUT, 100000, system-clock cycles allowed between consecutive falling edges inside a frame before the frame is aborted.
PARITY_CHECK, 0, 1 = reject frames whose odd parity fails; 0 = ignore the parity bit.

Ports:
CLK100MHZ  input  1  system clock; all logic on rising edge.
CPU_RESETN  input  1  asynchronous active-low reset.
PS2_CLK  input  1  raw PS/2 clock pin, asynchronous.
PS2_DATA  input  1  raw PS/2 data pin, asynchronous.
RAW_DATA  output  8  last accepted byte, including prefixes.
RAW_VALID  output  1  one-cycle strobe per accepted byte.
SCANCODE  output  8  scan code of the last key event.
BREAK  output  1  1 = key release; qualifies SCANCODE.
EXTENDED  output  1  1 = E0-prefixed code; qualifies SCANCODE.
KEY_VALID  output  1  one-cycle strobe per key event.
ERROR  output  1  one-cycle strobe on a framing, parity or timeout error.

Behaviour:
- Reset (asynchronous, CPU_RESETN=0):
  - All outputs 0; synchronisers and filtered levels set to 1 (idle bus).
  - State IDLE; bit counter, timeout counter and prefix flags cleared.
  - Reset mid-frame discards the partial frame with no strobe.
- Input conditioning:
  - Each pin passes through a 2-FF synchroniser, then the FILTER_LEN stability filter.
  - A falling edge is filtered PS2_CLK going 1->0; it is detected on the cycle the filtered level changes.
  - Data is sampled from filtered PS2_DATA on that same cycle.
  - Any pulse shorter than FILTER_LEN cycles is invisible.
- State machine (states IDLE, SHIFT, PARITY, STOP):
  - IDLE, on a falling edge: data 0 -> SHIFT with bit count 0 and timeout counter cleared; data 1 -> stay in IDLE, no error.
  - SHIFT: each falling edge shifts data into bit[count], LSB first; after the 8th bit -> PARITY.
  - PARITY: next falling edge captures the parity bit -> STOP.
  - STOP: next falling edge checks the stop bit, then returns to IDLE.
    - Stop=1 and (PARITY_CHECK=0 or XOR of the 8 data bits and parity = 1): byte accepted.
    - Otherwise ERROR pulses and the byte is discarded.
- Timeout:
  - In SHIFT, PARITY or STOP, the counter increments every cycle and clears on each falling edge.
  - When it reaches TIMEOUT: ERROR pulses, state -> IDLE, prefix flags cleared.
  - The counter saturates and is inactive in IDLE.
- Acceptance latency:
  - RAW_DATA updates and RAW_VALID pulses on the cycle after the stop-bit falling edge.
  - RAW_DATA holds its value until the next accepted byte.
- Prefix decoding (on accepted byte B):
  - B=E0: set the extended flag; no KEY_VALID.
  - B=F0: set the break flag; no KEY_VALID.
  - Any other B: SCANCODE=B, EXTENDED=extended flag, BREAK=break flag, all updated in the same cycle as RAW_VALID. KEY_VALID pulses in that same cycle, then both flags clear.
  - Repeated prefixes are idempotent. E1 and any other byte are treated as ordinary codes.
  - SCANCODE, BREAK and EXTENDED hold their values between events.
- ERROR clears both prefix flags.
- At most one of RAW_VALID and ERROR is asserted in any cycle.
- Strobes never last more than one cycle, whatever the timing of the lines.

Test Plan:
1. Frame 0x1C with parity 0, stop 1, PS/2 clock about 12.5 kHz -> RAW_DATA=1C with one RAW_VALID; KEY_VALID with SCANCODE=1C, BREAK=0, EXTENDED=0.
2. Bytes F0 then 1C -> two RAW_VALID pulses, exactly one KEY_VALID with SCANCODE=1C, BREAK=1; a following 1C gives BREAK=0.
3. E0, F0, 75 -> one KEY_VALID with SCANCODE=75, EXTENDED=1, BREAK=1; the next plain 75 gives EXTENDED=0.
4. PARITY_CHECK=1, byte 0x1C with parity bit 1 -> ERROR pulse; no RAW_VALID or KEY_VALID; SCANCODE unchanged. Same frame with PARITY_CHECK=0 -> accepted.
5. Stall PS2_CLK high after 4 data bits for TIMEOUT+10 cycles -> ERROR at TIMEOUT cycles; a full 0x45 frame afterwards is received correctly.
6. PS2_CLK low glitch of FILTER_LEN-3 cycles in IDLE -> no state change. Assert CPU_RESETN=0 mid-frame after an F0 -> all outputs 0; next byte 1C gives BREAK=0.
